// File: rtl/uart_pkg.sv
// uart_pkg: arbiter FSM state encodings and default watchdog timeout
package uart_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;
  localparam int default_timeout = 1024;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set req after last_grant, wrapping, gives idx and found
module rr_pick #(
  parameter int n = 4,
  parameter int w = $clog2(n)
) (
  input  logic [n-1:0] req,
  input  logic [w-1:0] last_grant,
  output logic [w-1:0] idx,
  output logic         found
);
  int c;
  always_comb begin
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int i = n; i >= 1; i--) begin
      c = (int'(last_grant) + i) % n;
      if (req[w'(c)]) begin
        idx = w'(c);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-locked round-robin arbiter of num_req byte streams onto one UART tx handshake, with idle watchdog
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int num_req = 4,
  parameter int timeout_cycles = default_timeout
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [num_req-1:0]         req_valid,
  input  logic [8*num_req-1:0]       req_data,
  input  logic [num_req-1:0]         req_last,
  output logic [num_req-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       grant_active,
  output logic [$clog2(num_req)-1:0] grant_id,
  output logic                       timeout_pulse
);
  localparam int idw = $clog2(num_req);
  localparam int wdw = timeout_cycles > 1 ? $clog2(timeout_cycles) : 1;
  arb_state_t state, state_d;
  logic [idw-1:0] last_grant, pick;
  logic [wdw-1:0] wd;
  logic [7:0] gbyte;
  logic found, gv, glast, open, accept, tx_fire, to_drain;
  rr_pick #(.n(num_req), .w(idw)) u_pick (
    .req(req_valid),
    .last_grant(last_grant),
    .idx(pick),
    .found(found)
  );
  always_comb begin
    gv = req_valid[grant_id];
    glast = req_last[grant_id];
    gbyte = req_data[8*grant_id +: 8];
    open = state == GRANT && (!tx_valid || tx_ready);
    accept = open && gv;
    tx_fire = tx_valid && tx_ready;
    timeout_pulse = timeout_cycles != 0 && state == GRANT && !gv && wd == wdw'(timeout_cycles - 1);
    req_ready = open ? num_req'(1) << grant_id : '0;
    grant_active = state != IDLE;
    to_drain = (accept && glast) || timeout_pulse;
    state_d = state == IDLE  ? (found ? GRANT : IDLE) :
              state == GRANT ? (to_drain ? DRAIN : GRANT) :
              (!tx_valid || tx_ready) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk)
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data <= '0;
      grant_id <= '0;
      last_grant <= idw'(num_req - 1);
      wd <= '0;
    end else begin
      if (state == IDLE && found) grant_id <= pick;
      if (accept) begin
        tx_data <= gbyte;
        tx_valid <= 1'b1;
      end else if (tx_fire) tx_valid <= 1'b0;
      if (to_drain) last_grant <= grant_id;
      wd <= state == GRANT && !gv && !timeout_pulse ? wd + 1'b1 : '0;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int nr = 4;
  typedef struct packed {
    logic [1:0] prev;
    logic [3:0] mask;
    logic [1:0] exp;
  } rr_vec_t;
  logic clk = 1'b0;
  logic rst, tx_valid, tx_ready, grant_active, timeout_pulse;
  logic [nr-1:0] req_valid, req_last, req_ready;
  logic [8*nr-1:0] req_data;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int checks = 0;
  int fails = 0;
  logic [8:0] q [nr][$];
  logic [7:0] log_d[$];
  logic [1:0] log_id[$];
  logic [nr-1:0] s_hs, s_ready;
  logic s_pulse, s_idle, s_txv;
  logic [7:0] s_data;
  rr_vec_t tbl[7];

  uart_tx_arbiter #(.num_req(nr), .timeout_cycles(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_active(grant_active),
    .grant_id(grant_id), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < nr; i++) begin
      req_valid[i] = q[i].size() != 0;
      req_data[8*i +: 8] = req_valid[i] ? q[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] && q[i][0][8];
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_hs = req_valid & req_ready;
    s_ready = req_ready;
    s_pulse = timeout_pulse;
    s_txv = tx_valid;
    s_data = tx_data;
    s_idle = !grant_active && !tx_valid;
    if (tx_valid && tx_ready) begin
      log_d.push_back(tx_data);
      log_id.push_back(grant_id);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < nr; i++)
      if (s_hs[i] && !rst) void'(q[i].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < nr; i++)
      if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 400) begin
      step();
      n++;
      done = s_idle && all_empty();
    end
    chk({name, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic wait_txv(input string name);
    int n = 0;
    s_txv = 1'b0;
    while (!s_txv && n < 20) begin
      step();
      n++;
    end
    chk({name, "_txv"}, 32'(s_txv), 32'd1);
  endtask

  task automatic chk_log(input string name, input int k, input logic [1:0] id, input logic [7:0] d);
    logic [9:0] act;
    act = k < log_d.size() ? {log_id[k], log_d[k]} : 10'h3ff;
    chk(name, 32'(act), 32'({id, d}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < nr; i++) q[i].delete();
    drive();
    step();
    step();
    rst = 1'b0;
    log_d.delete();
    log_id.delete();
  endtask

  initial begin
    tbl[0] = '{prev: 2'd0, mask: 4'b1111, exp: 2'd1};
    tbl[1] = '{prev: 2'd1, mask: 4'b0001, exp: 2'd0};
    tbl[2] = '{prev: 2'd3, mask: 4'b1010, exp: 2'd1};
    tbl[3] = '{prev: 2'd2, mask: 4'b1001, exp: 2'd3};
    tbl[4] = '{prev: 2'd3, mask: 4'b1000, exp: 2'd3};
    tbl[5] = '{prev: 2'd1, mask: 4'b0101, exp: 2'd2};
    tbl[6] = '{prev: 2'd2, mask: 4'b0011, exp: 2'd0};
    rst = 1'b1;
    tx_ready = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    do_reset();
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    @(posedge clk);
    #1;
    q[0].push_back(9'h041);
    q[0].push_back(9'h142);
    drive();
    run_idle("single");
    chk("single_count", 32'(log_d.size()), 32'd2);
    chk_log("single_b0", 0, 2'd0, 8'h41);
    chk_log("single_b1", 1, 2'd0, 8'h42);
    do_reset();
    q[0].push_back(9'h001);
    q[0].push_back(9'h102);
    q[2].push_back(9'h021);
    q[2].push_back(9'h122);
    drive();
    run_idle("lock");
    chk("lock_count", 32'(log_d.size()), 32'd4);
    chk_log("lock_b0", 0, 2'd0, 8'h01);
    chk_log("lock_b1", 1, 2'd0, 8'h02);
    chk_log("lock_b2", 2, 2'd2, 8'h21);
    chk_log("lock_b3", 3, 2'd2, 8'h22);
    do_reset();
    for (int i = 0; i < nr; i++) begin
      q[i].push_back({1'b1, 4'(i), 4'h1});
      q[i].push_back({1'b1, 4'(i), 4'h2});
    end
    drive();
    run_idle("rr4");
    chk("rr4_count", 32'(log_d.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      chk_log($sformatf("rr4_b%0d", k), k, 2'(k % 4), {4'(k % 4), 4'(k / 4 + 1)});
    for (int t = 0; t < 7; t++) begin
      q[tbl[t].prev].push_back(9'h1e0);
      drive();
      run_idle($sformatf("tbl%0d_prev", t));
      log_d.delete();
      log_id.delete();
      for (int i = 0; i < nr; i++)
        if (tbl[t].mask[i]) q[i].push_back({1'b1, 6'b100000, 2'(i)});
      drive();
      run_idle($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_count", t), 32'(log_d.size()), 32'($countones(tbl[t].mask)));
      chk_log($sformatf("tbl%0d_first", t), 0, tbl[t].exp, {6'b100000, tbl[t].exp});
    end
    log_d.delete();
    log_id.delete();
    q[0].push_back(9'h055);
    q[0].push_back(9'h156);
    tx_ready = 1'b0;
    drive();
    wait_txv("stall");
    for (int k = 0; k < 50; k++) begin
      step();
      chk($sformatf("stall_c%0d", k), {s_txv, s_ready, s_data}, {1'b1, 4'b0000, 8'h55});
    end
    tx_ready = 1'b1;
    run_idle("stall");
    chk("stall_count", 32'(log_d.size()), 32'd2);
    chk_log("stall_b0", 0, 2'd0, 8'h55);
    chk_log("stall_b1", 1, 2'd0, 8'h56);
    do_reset();
    q[1].push_back(9'h071);
    q[3].push_back(9'h191);
    drive();
    begin
      int n = 0;
      s_hs = '0;
      while (!s_hs[1] && n < 10) begin
        step();
        n++;
      end
      chk("wd_accept", 32'(s_hs[1]), 32'd1);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("wd_pulse_c%0d", k), 32'(s_pulse), 32'(k == 16));
    end
    run_idle("wd");
    chk("wd_count", 32'(log_d.size()), 32'd2);
    chk_log("wd_b0", 0, 2'd1, 8'h71);
    chk_log("wd_b1", 1, 2'd3, 8'h91);
    do_reset();
    q[0].push_back(9'h0a1);
    q[0].push_back(9'h0a2);
    q[0].push_back(9'h1a3);
    q[2].push_back(9'h1c1);
    tx_ready = 1'b0;
    drive();
    wait_txv("midrst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_grant_active", 32'(grant_active), 32'd0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    log_d.delete();
    log_id.delete();
    run_idle("midrst");
    chk("midrst_count", 32'(log_d.size()), 32'd3);
    chk_log("midrst_b0", 0, 2'd0, 8'ha2);
    chk_log("midrst_b2", 2, 2'd2, 8'hc1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter num_req, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter timeout_cycles, default 1024: the maximum idle gap inside a message before the grant is revoked; 0 disables the watchdog.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, num_req bits: per-requester byte valid.
REQ-006 The block SHALL have port req_data, input, 8*num_req bits: per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, num_req bits: marks the final byte of a requester's message.
REQ-008 The block SHALL have port req_ready, output, num_req bits: per-requester byte accept.
REQ-009 The block SHALL have port tx_valid, output, 1 bit: byte valid to the UART transmitter.
REQ-010 The block SHALL have port tx_data, output, 8 bits: byte to the UART transmitter.
REQ-011 The block SHALL have port tx_ready, input, 1 bit: transmitter ready; a transfer occurs when tx_valid and tx_ready are both high on a clk edge.
REQ-012 The block SHALL have port grant_active, output, 1 bit: high while a requester holds the grant.
REQ-013 The block SHALL have port grant_id, output, clog2(num_req) bits: index of the current or most recent grantee.
REQ-014 The block SHALL have port timeout_pulse, output, 1 bit: single-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, GRANT and DRAIN.
REQ-016 IDLE: when any req_valid bit is high, the block SHALL select, round-robin starting at last_grant+1 (wrapping modulo num_req), the first requester with valid high, load grant_id, and enter GRANT on the next cycle; arbitration latency is 1 cycle.
REQ-017 req_ready SHALL be all zero outside GRANT.
REQ-018 In GRANT, only bit grant_id of req_ready may be high, and it SHALL equal (!tx_valid || tx_ready).
REQ-019 A requester byte accept (req_valid && req_ready on the grantee) SHALL load the holding register (tx_data) and set tx_valid on the next cycle.
REQ-020 tx_valid SHALL clear after a transfer unless a new byte is accepted in the same cycle; back-to-back throughput SHALL be 1 byte per tx_ready cycle.
REQ-021 Accepting a byte with req_last high SHALL move the FSM to DRAIN and set last_grant to grant_id.
REQ-022 DRAIN SHALL return to IDLE on the cycle the held byte transfers, or immediately if tx_valid is already low.
REQ-023 The grant SHALL be message-locked: no other requester is served until the grantee's last byte has been accepted or the watchdog fires.
REQ-024 Watchdog: in GRANT, a counter SHALL count consecutive cycles with the grantee's req_valid low, clearing on any grantee valid.
REQ-025 When the watchdog count reaches timeout_cycles (nonzero), the block SHALL pulse timeout_pulse, set last_grant to grant_id, and enter DRAIN; an already-held byte is still sent.
REQ-026 grant_active SHALL be high in GRANT and DRAIN.
REQ-027 tx_data SHALL be stable while tx_valid is high and tx_ready is low.
REQ-028 req_valid from non-granted requesters SHALL be ignored, and no byte SHALL be lost or duplicated.

Reset
REQ-029 rst SHALL force the following values on the next edge, including mid-message: FSM=IDLE, tx_valid=0, tx_data=0x00, req_ready=0, grant_active=0, grant_id=0, timeout_pulse=0, watchdog=0, last_grant=num_req-1 (requester 0 wins first).
REQ-030 A byte held at reset SHALL be discarded.

Structure
REQ-031 FSM state encodings and the default timeout constant SHALL reside in shared package uart_pkg.
REQ-032 The round-robin priority picker SHALL be the sub-module rr_pick: combinational, taking req and last_grant and producing the grant index and a found flag.

Verification
REQ-033 After reset, req_valid=0b0001 with bytes 0x41,0x42(last) and tx_ready held high: tx_data sequence SHALL be 0x41,0x42; grant_id=0; return to IDLE.
REQ-034 Requesters 0 and 2 each present a 2-byte message simultaneously: output SHALL be both of requester 0's bytes, then both of requester 2's bytes, with no interleaving.
REQ-035 All 4 requesters send repeated 1-byte messages: grant order SHALL be 0,1,2,3,0.
REQ-036 With tx_ready low for 50 cycles holding 0x55: tx_data SHALL stay 0x55, tx_valid SHALL stay 1, and req_ready SHALL be 0.
REQ-037 With timeout_cycles=16, requester 1 sends one non-last byte and then drops valid: timeout_pulse SHALL be 1 on the 16th idle cycle, after which requester 3 SHALL be granted.
REQ-038 rst asserted mid-message with tx_valid=1: the next cycle SHALL show tx_valid=0, all req_ready=0 and grant_active=0, and the next grant SHALL go to requester 0.
